gemm_result_streamer: RTL and testbench
=======================================

// Module: gemm_result_streamer
// PURPOSE
//  Reader side of the C_full result array written by gemm_tiled_controller_3d.
//  On the controller's done pulse, snapshots the complete M_TOTAL x N_TOTAL C matrix.
//  Streams it out row-major over a valid/ready interface, freeing the controller for the next job.
//  Sits between the GEMM controller and the downstream writeback/DMA path.
// PARAMETERS
//  M_TOTAL  8      rows of C
//  N_TOTAL  8      cols of C
//  ACC_W    backbone_pkg::ACC_W   width of each C element (signed)
// PORTS
//  clk        in   1                    clock
//  rst_n      in   1                    async active-low reset
//  done       in   1                    1-cycle pulse from controller: C_full valid this cycle
//  C_full     in   [M_TOTAL][N_TOTAL] x ACC_W signed   controller result array
//  clr_err    in   1                    sync clear of drop_err
//  m_valid    out  1                    output element valid
//  m_ready    in   1                    downstream ready
//  m_data     out  ACC_W signed         element C[m_row][m_col]
//  m_row      out  $clog2(M_TOTAL)      row index of m_data
//  m_col      out  $clog2(N_TOTAL)      col index of m_data
//  m_last     out  1                    high with the final element C[M-1][N-1]
//  busy       out  1                    high while in STREAM
//  frame_done out  1                    1-cycle pulse after the last handshake
//  drop_err   out  1                    sticky: a done arrived while the frame could not be accepted
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; m_valid, m_last, busy, frame_done, drop_err = 0.
//    m_row, m_col, m_data = 0. Buffer contents don't-care. Takes effect immediately, even mid-frame.
//  - FSM IDLE -> STREAM: done=1 sampled at edge t -> C_full copied to internal buffer at t.
//    Indices reset to (0,0). m_valid=1 from t+1 with m_data=C[0][0] (1-cycle latency).
//  - STREAM: handshake = m_valid & m_ready.
//    On handshake col++; when col wraps at N_TOTAL-1, col=0 and row++.
//  - m_data/m_row/m_col/m_last are held stable while m_valid & !m_ready.
//    m_valid never drops without a handshake.
//  - m_last = (row==M_TOTAL-1 && col==N_TOTAL-1) while m_valid.
//  - Last handshake: frame_done=1 next cycle; state -> IDLE, m_valid=0,
//    unless the back-to-back case below applies.
//  - Back-to-back: done coincident with the last handshake -> new snapshot taken, frame_done still pulses.
//    Stay in STREAM at (0,0); m_valid stays 1 with the new C[0][0]; no drop_err.
//  - done in STREAM at any other time: ignored (buffer untouched), drop_err <= 1.
//  - drop_err cleared only by reset or clr_err=1. If clr_err and a new drop occur together, set wins.
//  - done while in IDLE: always accepted.
//  - m_ready may be high in IDLE: no effect.
//  - busy = (state==STREAM). Throughput is 1 element/cycle with m_ready held high.
//    A frame takes M_TOTAL*N_TOTAL cycles (64 at default).
//  - Elements pass through unmodified. No width conversion; sign preserved.
// STRUCTURE
//  - backbone_pkg: reuse ACC_W; add typedef logic signed [ACC_W-1:0] acc_t,
//    shared with the controller and writeback.
//  - Single module: 2-state FSM, row/col counters, M*N x acc_t snapshot register array.
//  - Output mux selects buf[row][col]; no sub-module needed.
// TESTING
//  1. Reset, then done with C[i][j]=i*8+j, m_ready=1:
//     64 beats, values 0..63 in order. m_last only on beat 63; frame_done 1 cycle after.
//  2. m_ready pattern 1,0,0,1 repeating:
//     data/indices stable across stalls, no beat lost or duplicated, all 64 values correct.
//  3. Changing C_full to all -1 one cycle after done:
//     streamed frame still carries the original snapshot, e.g. C[0][0]=0.
//  4. Extra done at beat 10:
//     drop_err=1, stream unaffected. clr_err -> drop_err=0.
//  5. done coincident with the last handshake, second C all = -5 (negative, ACC_W sign):
//     no m_valid gap, second frame starts at -5, drop_err=0, two frame_done pulses.
//  6. rst_n=0 at beat 20:
//     m_valid=0 and busy=0 immediately. After release, the next done streams a full fresh frame from (0,0).

Source files
------------

// File: rtl/backbone_pkg.sv
// Shared types for the GEMM datapath: accumulator element width and type,
// plus the result-streamer FSM state encoding.
package backbone_pkg;

    localparam int ACC_W = 32;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } strm_state_t;

endpackage

// File: rtl/gemm_result_streamer.sv
// Snapshots the controller's C matrix on done and streams it row-major
// over valid/ready.
// Ports: clk, rst_n (async low), done, C_full, clr_err, m_ready in;
//        m_valid, m_data, m_row, m_col, m_last, busy, frame_done,
//        drop_err out.
import backbone_pkg::*;

module gemm_result_streamer #(
    parameter int M_TOTAL = 8,
    parameter int N_TOTAL = 8,
    localparam int RW = (M_TOTAL > 1) ? $clog2(M_TOTAL) : 1,
    localparam int CW = (N_TOTAL > 1) ? $clog2(N_TOTAL) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                done,
    input  acc_t [M_TOTAL-1:0][N_TOTAL-1:0]     C_full,
    input  logic                                clr_err,
    output logic                                m_valid,
    input  logic                                m_ready,
    output acc_t                                m_data,
    output logic [RW-1:0]                       m_row,
    output logic [CW-1:0]                       m_col,
    output logic                                m_last,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                drop_err
);

    strm_state_t   r_state;
    strm_state_t   w_state_nxt;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row_nxt;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col_nxt;
    logic          r_frame_done;
    logic          r_drop_err;
    logic          w_busy;
    logic          w_hs;
    logic          w_last;
    logic          w_load;
    logic          w_drop;

    acc_t r_buf [M_TOTAL][N_TOTAL];

    assign w_busy = (r_state == S_STREAM);
    assign w_hs   = w_busy & m_ready;
    assign w_last = w_busy
                  & (r_row == RW'(M_TOTAL - 1))
                  & (r_col == CW'(N_TOTAL - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (done) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_STREAM;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_row_nxt = '0;
                        w_col_nxt = '0;
                        // A done landing on the final beat chains a new frame
                        if (done) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else if (r_col == CW'(N_TOTAL - 1)) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + RW'(1);
                    end else begin
                        w_col_nxt = r_col + CW'(1);
                    end
                end
                if (done && !(w_hs && w_last)) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_frame_done <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_frame_done <= w_hs & w_last;
            // New drop beats a simultaneous clear
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end else if (clr_err) begin
                r_drop_err <= 1'b0;
            end
        end
    end

    // Snapshot storage needs no reset; contents only matter once loaded
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int i = 0; i < M_TOTAL; i++) begin
                for (int j = 0; j < N_TOTAL; j++) begin
                    r_buf[i][j] <= C_full[i][j];
                end
            end
        end
    end

    assign m_valid    = w_busy;
    assign busy       = w_busy;
    assign m_data     = w_busy ? r_buf[r_row][r_col] : '0;
    assign m_row      = r_row;
    assign m_col      = r_col;
    assign m_last     = w_last;
    assign frame_done = r_frame_done;
    assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_gemm_result_streamer.sv
// Randomized scoreboard bench for gemm_result_streamer.
// Model queues whole frames on accepted done; monitor pops on handshakes.
import backbone_pkg::*;

module tb_gemm_result_streamer;

    localparam int M = 8;
    localparam int N = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 done;
    acc_t [M-1:0][N-1:0]  C_full;
    logic                 clr_err;
    logic                 m_valid;
    logic                 m_ready;
    acc_t                 m_data;
    logic [2:0]           m_row;
    logic [2:0]           m_col;
    logic                 m_last;
    logic                 busy;
    logic                 frame_done;
    logic                 drop_err;

    gemm_result_streamer #(.M_TOTAL(M), .N_TOTAL(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .done       (done),
        .C_full     (C_full),
        .clr_err    (clr_err),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_row      (m_row),
        .m_col      (m_col),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        acc_t d;
        int   r;
        int   c;
        bit   last;
    } beat_t;

    beat_t q[$];
    int    rem      = 0;
    bit    exp_fd   = 0;
    bit    exp_drop = 0;
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    rmode    = 0;
    int    pc       = 0;
    int    fd_seen  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is 64 pending beats; done is taken
    // only when nothing is left pending after this edge's beat.
    always @(posedge clk or negedge rst_n) begin
        bit hs;
        bit acc;
        if (!rst_n) begin
            rem      = 0;
            exp_fd   = 0;
            exp_drop = 0;
            q.delete();
        end else begin
            hs     = (rem > 0) && m_ready;
            exp_fd = hs && (rem == 1);
            if (hs) rem--;
            acc = done && (rem == 0);
            if (acc) begin
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < N; j++)
                        q.push_back('{C_full[i][j], i, j, (i == M-1) && (j == N-1)});
                rem = M * N;
            end
            if (done && !acc) exp_drop = 1;
            else if (clr_err) exp_drop = 0;
        end
    end

    // Monitor
    bit    hold = 0;
    beat_t held;
    always @(negedge clk) begin
        beat_t e;
        chk("valid", m_valid, rem > 0);
        chk("busy", busy, rem > 0);
        chk("frame_done", frame_done, exp_fd);
        chk("drop_err", drop_err, exp_drop);
        if (frame_done) fd_seen++;
        if (m_valid) begin
            if (hold) begin
                chk("stall_data", m_data, held.d);
                chk("stall_row", m_row, held.r);
                chk("stall_col", m_col, held.c);
            end
            if (m_ready) begin
                hold = 0;
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_extra: got beat with empty queue at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("data", m_data, e.d);
                    chk("row", m_row, e.r);
                    chk("col", m_col, e.c);
                    chk("last", m_last, e.last);
                end
            end else begin
                hold   = 1;
                held.d = m_data;
                held.r = m_row;
                held.c = m_col;
            end
        end else begin
            hold = 0;
            chk("idle_data", m_data, 0);
            chk("idle_last", m_last, 0);
        end
    end

    always begin
        @(posedge clk);
        #1;
        case (rmode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (pc % 4 == 0) || (pc % 4 == 3);
                pc++;
            end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_c();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                C_full[i][j] = acc_t'($urandom);
    endtask

    task automatic fill_c(input int v);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                C_full[i][j] = acc_t'(v);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (rem != 0 && k < lim) begin
            tick();
            k++;
        end
        if (rem != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d beats still pending after %0d cycles", rem, lim);
        end
        tick();
        tick();
    endtask

    initial begin
        int k;
        int fd0;
        rst_n   = 1'b0;
        done    = 1'b0;
        clr_err = 1'b0;
        m_ready = 1'b0;
        fill_c(0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Ordered frame, ready always high
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                C_full[i][j] = acc_t'(i * 8 + j);
        pulse_done();
        wait_idle(100);

        // 1,0,0,1 ready pattern
        rmode = 1;
        pc    = 0;
        rand_c();
        pulse_done();
        wait_idle(400);
        rmode = 0;

        // Input changes after snapshot must not leak into the frame
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                C_full[i][j] = acc_t'(i * 8 + j);
        pulse_done();
        fill_c(-1);
        wait_idle(100);

        // Dropped done mid-frame, then clear; then clear+drop together
        rand_c();
        pulse_done();
        repeat (9) tick();
        fill_c(-1);
        pulse_done();
        wait_idle(100);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        rand_c();
        pulse_done();
        repeat (5) tick();
        done    = 1'b1;
        clr_err = 1'b1;
        tick();
        done    = 1'b0;
        clr_err = 1'b0;
        wait_idle(100);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();

        // Back-to-back frame, second all -5
        fd0 = fd_seen;
        rand_c();
        pulse_done();
        k = 0;
        while (rem != 1 && k < 100) begin
            tick();
            k++;
        end
        fill_c(-5);
        pulse_done();
        wait_idle(100);
        chk("b2b_frame_done_count", fd_seen - fd0, 2);

        // Async reset mid-frame, then a fresh frame
        rand_c();
        pulse_done();
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rand_c();
        pulse_done();
        wait_idle(100);

        // Random traffic
        rmode = 2;
        for (int c = 0; c < 600; c++) begin
            rand_c();
            done    = ($urandom_range(0, 39) == 0);
            clr_err = ($urandom_range(0, 29) == 0);
            tick();
        end
        done    = 1'b0;
        clr_err = 1'b0;
        wait_idle(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
